// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR write arbiter.
// Holds the FSM state encoding, response codes and channel-ID width helper.
package ddr_arb_pkg;

    function automatic int ch_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/ddr_wr_id_fifo.sv
// Channel-ID FIFO tracking which requester owns each response in flight.
// Simultaneous push and pop are both honoured, even when full.
import ddr_arb_pkg::*;

module ddr_wr_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ddr_wr_arb.sv
// Round-robin multi-channel write front-end for the DDR write port.
// Optional DDR_WR_ARB_PRIO_EN gives channel 0 strict priority.
import ddr_arb_pkg::*;

module ddr_wr_arb #(
    parameter int CH_NUM      = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int SIZE_WIDTH  = 16,
    parameter int DATA_WIDTH  = 64,
    parameter int OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [CH_NUM-1:0]            ch_wreq_valid,
    output logic [CH_NUM-1:0]            ch_wreq_ready,
    input  logic [CH_NUM*ADDR_WIDTH-1:0] ch_wreq_addr,
    input  logic [CH_NUM*SIZE_WIDTH-1:0] ch_wreq_size,
    input  logic [CH_NUM-1:0]            ch_wdata_valid,
    output logic [CH_NUM-1:0]            ch_wdata_ready,
    input  logic [CH_NUM-1:0]            ch_wdata_last,
    input  logic [CH_NUM*DATA_WIDTH-1:0] ch_wdata,
    output logic [CH_NUM-1:0]            ch_wresp_valid,
    output logic [1:0]                   ch_wresp,
    output logic                         ddr_wreq_valid,
    input  logic                         ddr_wreq_ready,
    output logic [ADDR_WIDTH-1:0]        ddr_wreq_addr,
    output logic [SIZE_WIDTH-1:0]        ddr_wreq_size,
    output logic                         ddr_wdata_valid,
    input  logic                         ddr_wdata_ready,
    output logic                         ddr_wdata_last,
    output logic [DATA_WIDTH-1:0]        ddr_wdata,
    input  logic                         ddr_wresp_valid,
    input  logic [1:0]                   ddr_wresp,
    output logic                         err_orphan
);

    localparam int CH_ID_W = ch_id_w(CH_NUM);

    state_t               state;
    state_t               state_nxt;
    logic [CH_ID_W-1:0]   grant;
    logic [CH_ID_W-1:0]   grant_nxt;
    logic [CH_ID_W-1:0]   last_grant;
    logic [CH_ID_W-1:0]   last_grant_nxt;
    logic [CH_ID_W-1:0]   rr_pick;
    logic [CH_ID_W-1:0]   cand;
    logic                 rr_hit;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CH_ID_W-1:0]   fifo_head;

    logic [ADDR_WIDTH-1:0] addr_a [CH_NUM];
    logic [SIZE_WIDTH-1:0] size_a [CH_NUM];
    logic [DATA_WIDTH-1:0] data_a [CH_NUM];

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        assign addr_a[c] = ch_wreq_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
        assign size_a[c] = ch_wreq_size[c*SIZE_WIDTH +: SIZE_WIDTH];
        assign data_a[c] = ch_wdata[c*DATA_WIDTH +: DATA_WIDTH];
    end

    // Circular search starting just after the previous winner.
    always_comb begin
        rr_pick = last_grant;
        rr_hit  = 1'b0;
        cand    = '0;
        for (int i = 1; i <= CH_NUM; i++) begin
            cand = CH_ID_W'((int'(last_grant) + i) % CH_NUM);
            if (!rr_hit && ch_wreq_valid[cand]) begin
                rr_hit  = 1'b1;
                rr_pick = cand;
            end
        end
`ifdef DDR_WR_ARB_PRIO_EN
        if (ch_wreq_valid[0]) begin
            rr_pick = '0;
        end
`endif
    end

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        last_grant_nxt  = last_grant;
        push            = 1'b0;
        ddr_wreq_valid  = 1'b0;
        ddr_wreq_addr   = '0;
        ddr_wreq_size   = '0;
        ch_wreq_ready   = '0;
        ddr_wdata_valid = 1'b0;
        ddr_wdata_last  = 1'b0;
        ddr_wdata       = '0;
        ch_wdata_ready  = '0;
        unique case (state)
            IDLE: begin
                if (|ch_wreq_valid && !fifo_full) begin
                    grant_nxt = rr_pick;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                ddr_wreq_valid       = ch_wreq_valid[grant];
                ddr_wreq_addr        = addr_a[grant];
                ddr_wreq_size        = size_a[grant];
                ch_wreq_ready[grant] = ddr_wreq_ready;
                if (ch_wreq_valid[grant] && ddr_wreq_ready) begin
                    push      = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                ddr_wdata_valid       = ch_wdata_valid[grant];
                ddr_wdata_last        = ch_wdata_last[grant];
                ddr_wdata             = data_a[grant];
                ch_wdata_ready[grant] = ddr_wdata_ready;
                if (ch_wdata_valid[grant] && ddr_wdata_ready
                    && ch_wdata_last[grant]) begin
                    last_grant_nxt = grant;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_ID_W'(CH_NUM - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    ddr_wr_id_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (CH_ID_W)
    ) u_id_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (grant),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Responses carry no ID; the FIFO head names the owner.
    assign pop = ddr_wresp_valid & ~fifo_empty;

    always_comb begin
        ch_wresp_valid = '0;
        ch_wresp       = '0;
        if (pop) begin
            ch_wresp_valid[fifo_head] = 1'b1;
            ch_wresp                  = ddr_wresp;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_orphan <= 1'b0;
        end else if (ddr_wresp_valid && fifo_empty) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_wr_arb.sv
// Directed self-checking bench for ddr_wr_arb (4 channels, 64-bit data).
// Table of single-channel bursts plus hand sequences for arbitration corners.
import ddr_arb_pkg::*;

module tb_ddr_wr_arb;

    localparam int CH = 4;
    localparam int AW = 32;
    localparam int SW = 16;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rstn;
    logic [CH-1:0]   ch_wreq_valid;
    logic [CH-1:0]   ch_wreq_ready;
    logic [CH*AW-1:0] ch_wreq_addr;
    logic [CH*SW-1:0] ch_wreq_size;
    logic [CH-1:0]   ch_wdata_valid;
    logic [CH-1:0]   ch_wdata_ready;
    logic [CH-1:0]   ch_wdata_last;
    logic [CH*DW-1:0] ch_wdata;
    logic [CH-1:0]   ch_wresp_valid;
    logic [1:0]      ch_wresp;
    logic            ddr_wreq_valid;
    logic            ddr_wreq_ready;
    logic [AW-1:0]   ddr_wreq_addr;
    logic [SW-1:0]   ddr_wreq_size;
    logic            ddr_wdata_valid;
    logic            ddr_wdata_ready;
    logic            ddr_wdata_last;
    logic [DW-1:0]   ddr_wdata;
    logic            ddr_wresp_valid;
    logic [1:0]      ddr_wresp;
    logic            err_orphan;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    ddr_wr_arb u_dut (
        .clk             (clk),
        .rstn            (rstn),
        .ch_wreq_valid   (ch_wreq_valid),
        .ch_wreq_ready   (ch_wreq_ready),
        .ch_wreq_addr    (ch_wreq_addr),
        .ch_wreq_size    (ch_wreq_size),
        .ch_wdata_valid  (ch_wdata_valid),
        .ch_wdata_ready  (ch_wdata_ready),
        .ch_wdata_last   (ch_wdata_last),
        .ch_wdata        (ch_wdata),
        .ch_wresp_valid  (ch_wresp_valid),
        .ch_wresp        (ch_wresp),
        .ddr_wreq_valid  (ddr_wreq_valid),
        .ddr_wreq_ready  (ddr_wreq_ready),
        .ddr_wreq_addr   (ddr_wreq_addr),
        .ddr_wreq_size   (ddr_wreq_size),
        .ddr_wdata_valid (ddr_wdata_valid),
        .ddr_wdata_ready (ddr_wdata_ready),
        .ddr_wdata_last  (ddr_wdata_last),
        .ddr_wdata       (ddr_wdata),
        .ddr_wresp_valid (ddr_wresp_valid),
        .ddr_wresp       (ddr_wresp),
        .err_orphan      (err_orphan)
    );

    typedef struct {
        int          ch;
        logic [31:0] addr;
        logic [15:0] size;
        int          beats;
        logic [1:0]  resp;
        logic [3:0]  exp_onehot;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int c);
        logic [3:0] r;
        r = '0;
        if (c >= 0 && c < CH) r[c] = 1'b1;
        return r;
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < CH; i++) begin
            if (v == onehot(i)) r = i;
        end
        return r;
    endfunction

    function automatic logic [63:0] beat_data(input int c, input int b);
        return {32'hC0DE_0000 + 32'(c), 32'(b)};
    endfunction

    task automatic clear_inputs();
        ch_wreq_valid   = '0;
        ch_wreq_addr    = '0;
        ch_wreq_size    = '0;
        ch_wdata_valid  = '0;
        ch_wdata_last   = '0;
        ch_wdata        = '0;
        ddr_wreq_ready  = 1'b0;
        ddr_wdata_ready = 1'b0;
        ddr_wresp_valid = 1'b0;
        ddr_wresp       = 2'b00;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_beat(input int b);
        for (int c = 0; c < CH; c++) begin
            ch_wdata[c*DW +: DW] = beat_data(c, b);
        end
    endtask

    task automatic run_vec(input vec_t v);
        for (int c = 0; c < CH; c++) begin
            ch_wreq_addr[c*AW +: AW] = (c == v.ch) ? v.addr : 32'hDEAD_0000 + 32'(c);
            ch_wreq_size[c*SW +: SW] = (c == v.ch) ? v.size : 16'h0BA0 + 16'(c);
        end
        ch_wreq_valid  = onehot(v.ch);
        ddr_wreq_ready = 1'b1;
        @(negedge clk);
        chk("vec_wreq_valid", 64'(ddr_wreq_valid), 64'd1);
        chk("vec_wreq_addr", 64'(ddr_wreq_addr), 64'(v.addr));
        chk("vec_wreq_size", 64'(ddr_wreq_size), 64'(v.size));
        chk("vec_wreq_ready", 64'(ch_wreq_ready), 64'(v.exp_onehot));
        @(negedge clk);
        chk("vec_wreq_outside_req", 64'(ddr_wreq_valid), 64'd0);
        ch_wreq_valid   = '0;
        ddr_wdata_ready = 1'b1;
        ch_wdata_valid  = onehot(v.ch);
        for (int b = 0; b < v.beats; b++) begin
            set_beat(b);
            ch_wdata_last = (b == v.beats - 1) ? onehot(v.ch) : 4'b0000;
            #1;
            chk("vec_wdata_valid", 64'(ddr_wdata_valid), 64'd1);
            chk("vec_wdata", ddr_wdata, beat_data(v.ch, b));
            chk("vec_wdata_last", 64'(ddr_wdata_last), 64'(b == v.beats - 1));
            chk("vec_wdata_ready", 64'(ch_wdata_ready), 64'(v.exp_onehot));
            @(negedge clk);
        end
        chk("vec_burst_done", 64'(ddr_wdata_valid), 64'd0);
        ch_wdata_valid  = '0;
        ch_wdata_last   = '0;
        ddr_wresp_valid = 1'b1;
        ddr_wresp       = v.resp;
        #1;
        chk("vec_wresp_valid", 64'(ch_wresp_valid), 64'(v.exp_onehot));
        chk("vec_wresp_code", 64'(ch_wresp), 64'(v.resp));
        @(negedge clk);
        ddr_wresp_valid = 1'b0;
        #1;
        chk("vec_wresp_strobe", 64'(ch_wresp_valid), 64'd0);
    endtask

    initial begin
        int gseq [5];
        int acc [6];
        int ng;
        int na;
        int cur;
        int beat;
        bit fin;
        bit seen;
        int psq [4];
        int exp_p [4];

        vecs[0] = '{2, 32'h0000_1000, 16'd64, 8, OKAY, 4'b0100};
        vecs[1] = '{0, 32'h2000_0040, 16'd16, 2, SLVERR, 4'b0001};
        vecs[2] = '{3, 32'hFFFF_FFF8, 16'd8, 1, OKAY, 4'b1000};
        vecs[3] = '{1, 32'h0000_0000, 16'hFFFF, 4, SLVERR, 4'b0010};

        rstn = 1'b0;
        clear_inputs();
        #1;
        chk("rst_wreq_valid", 64'(ddr_wreq_valid), 64'd0);
        chk("rst_wdata_valid", 64'(ddr_wdata_valid), 64'd0);
        chk("rst_ch_wreq_ready", 64'(ch_wreq_ready), 64'd0);
        chk("rst_ch_wresp_valid", 64'(ch_wresp_valid), 64'd0);
        chk("rst_err_orphan", 64'(err_orphan), 64'd0);
        apply_reset();

        for (int k = 0; k < 4; k++) begin
            run_vec(vecs[k]);
        end

        // Continuous requests from all channels, 3-beat bursts.
        apply_reset();
        for (int k = 0; k < 5; k++) gseq[k] = -1;
        ng = 0; cur = -1; beat = 0; fin = 0;
        ch_wreq_valid   = 4'hF;
        ch_wdata_valid  = 4'hF;
        ddr_wreq_ready  = 1'b1;
        ddr_wdata_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(negedge clk);
            ddr_wresp_valid = 1'b0;
            ch_wdata_last   = '0;
            if (ddr_wreq_valid) begin
                cur = oh_idx(ch_wreq_ready);
                if (ng < 5) gseq[ng] = cur;
                ng++;
                beat = 0;
            end else if (ddr_wdata_valid) begin
                chk("rr_hold", 64'(ch_wdata_ready), 64'(onehot(cur)));
                if (beat == 0) begin
                    ddr_wresp_valid = 1'b1;
                    ddr_wresp       = OKAY;
                    #1;
                    chk("rr_resp", 64'(ch_wresp_valid), 64'(onehot(cur)));
                end
                if (beat == 2) begin
                    ch_wdata_last = 4'hF;
                    if (ng >= 5) fin = 1;
                end
                beat++;
            end
        end
        @(negedge clk);
        clear_inputs();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_grant_%0d", k), 64'(gseq[k]), 64'(k % 4));
        end

        // Response backlog: FIFO fills after four requests.
        apply_reset();
        for (int k = 0; k < 6; k++) acc[k] = -1;
        na = 0;
        ch_wreq_valid   = 4'hF;
        ch_wdata_valid  = 4'hF;
        ch_wdata_last   = 4'hF;
        ddr_wreq_ready  = 1'b1;
        ddr_wdata_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (ddr_wreq_valid && ch_wreq_ready != 0) begin
                if (na < 6) acc[na] = oh_idx(ch_wreq_ready);
                na++;
            end
        end
        chk("bl_accept_count", 64'(na), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bl_order_%0d", k), 64'(acc[k]), 64'(k));
        end
        chk("bl_ready_held", 64'(ch_wreq_ready), 64'd0);
        ddr_wresp_valid = 1'b1;
        ddr_wresp       = SLVERR;
        #1;
        chk("bl_pop0", 64'(ch_wresp_valid), 64'b0001);
        chk("bl_pop0_code", 64'(ch_wresp), 64'(SLVERR));
        @(negedge clk);
        ddr_wresp_valid = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (ddr_wreq_valid) begin
                seen = 1;
                chk("bl_next_accept", 64'(ch_wreq_ready), 64'b0001);
            end
        end
        chk("bl_next_seen", 64'(seen), 64'd1);
        @(negedge clk);
        ch_wreq_valid = '0;
        @(negedge clk);
        ch_wdata_valid = '0;
        ch_wdata_last  = '0;
        exp_p = '{1, 2, 3, 0};
        for (int k = 0; k < 4; k++) begin
            ddr_wresp_valid = 1'b1;
            ddr_wresp       = OKAY;
            #1;
            psq[k] = oh_idx(ch_wresp_valid);
            chk($sformatf("bl_resp_%0d", k), 64'(psq[k]), 64'(exp_p[k]));
            @(negedge clk);
        end
        ddr_wresp_valid = 1'b0;
        chk("bl_no_orphan", 64'(err_orphan), 64'd0);

        // Response with nothing outstanding.
        apply_reset();
        ddr_wresp_valid = 1'b1;
        ddr_wresp       = SLVERR;
        #1;
        chk("orph_no_strobe", 64'(ch_wresp_valid), 64'd0);
        @(negedge clk);
        ddr_wresp_valid = 1'b0;
        chk("orph_set", 64'(err_orphan), 64'd1);
        repeat (3) @(negedge clk);
        chk("orph_sticky", 64'(err_orphan), 64'd1);

        // Asynchronous reset in the middle of a burst.
        apply_reset();
        chk("rst_clears_orphan", 64'(err_orphan), 64'd0);
        ch_wreq_addr[2*AW +: AW] = 32'h0000_5000;
        ch_wreq_size[2*SW +: SW] = 16'd32;
        ch_wreq_valid  = 4'b0100;
        ddr_wreq_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ch_wreq_valid   = '0;
        ch_wdata_valid  = 4'b0100;
        ddr_wdata_ready = 1'b1;
        set_beat(0);
        #1;
        chk("mid_in_data", 64'(ddr_wdata_valid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_wdata_valid", 64'(ddr_wdata_valid), 64'd0);
        chk("mid_wdata", ddr_wdata, 64'd0);
        chk("mid_wdata_ready", 64'(ch_wdata_ready), 64'd0);
        chk("mid_wreq_valid", 64'(ddr_wreq_valid), 64'd0);
        chk("mid_wreq_addr", 64'(ddr_wreq_addr), 64'd0);
        clear_inputs();
        @(negedge clk);
        rstn          = 1'b1;
        ch_wreq_valid = 4'hF;
        @(negedge clk);
        chk("post_rst_valid", 64'(ddr_wreq_valid), 64'd1);
        chk("post_rst_grant", 64'(ch_wreq_ready), 64'd0);
        ddr_wreq_ready = 1'b1;
        #1;
        chk("post_rst_grant0", 64'(ch_wreq_ready), 64'b0001);

        // Channels 0 and 3 contending.
        apply_reset();
        for (int k = 0; k < 4; k++) gseq[k] = -1;
        ng = 0;
        ch_wreq_valid   = 4'b1001;
        ch_wdata_valid  = 4'b1001;
        ch_wdata_last   = 4'b1001;
        ddr_wreq_ready  = 1'b1;
        ddr_wdata_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && ng < 4; cyc++) begin
            @(negedge clk);
            ddr_wresp_valid = ddr_wdata_valid;
            if (ddr_wreq_valid) begin
                gseq[ng] = oh_idx(ch_wreq_ready);
                ng++;
            end
        end
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
`ifdef DDR_WR_ARB_PRIO_EN
            chk($sformatf("prio_grant_%0d", k), 64'(gseq[k]), 64'd0);
`else
            chk($sformatf("prio_grant_%0d", k), 64'(gseq[k]), 64'((k % 2) * 3));
`endif
        end
        apply_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
